gearbox_wr_arb: RTL
===================

GEARBOX_WR_ARB -- requirements
Module: gearbox_wr_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (fixed 4 in this revision).
REQ-002 SHALL have parameter MAX_BURST, default 8, max words per grant, range 1..16.
REQ-003 SHALL have port clk_400MHz  input  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port res_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  input  4  per-requester word valid.
REQ-006 SHALL have port req_data  input  64  per-requester 16-bit word; requester i on bits [16i+15:16i].
REQ-007 SHALL have port req_last  input  4  per-requester end-of-packet marker, qualified by req_valid.
REQ-008 SHALL have port req_ready  output  4  per-requester accept; a word transfers when req_valid[i] and req_ready[i] are both 1.
REQ-009 SHALL have port full  input  1  gearbox write-side full flag.
REQ-010 SHALL have port shift_in  output  1  word-write strobe to gearbox.
REQ-011 SHALL have port data_in  output  16  word to gearbox.
REQ-012 SHALL have port grant_id  output  2  index of the current or last granted requester.
REQ-013 SHALL have port busy  output  1  high while in state GRANT.

Function
- REQ-014 SHALL implement FSM states IDLE and GRANT.
- REQ-015 In IDLE, SHALL select the first requester with req_valid high, searching round-robin from rr_ptr upward modulo 4.
- REQ-016 On selection, SHALL register grant_id and enter GRANT next cycle; req_ready stays 0 during IDLE, so arbitration costs 1 cycle.
- REQ-017 In IDLE with no req_valid bit set, SHALL remain in IDLE.
- REQ-018 Output stage SHALL be a 1-word register (ovalid, odata); shift_in = ovalid, data_in = odata, both driven directly from flops.
- REQ-019 The output word SHALL be consumed in any cycle where shift_in=1 and full=0; when full=1, ovalid and odata SHALL hold, so no word is lost.
- REQ-020 req_ready[grant_id] SHALL be 1 in GRANT when the output register is empty or consumed this cycle; all other req_ready bits SHALL be 0.
- REQ-021 An accepted word SHALL load the output register on the next edge, giving 1-cycle latency from accept to shift_in.
- REQ-022 A 4-bit burst counter SHALL be cleared on entry to GRANT and incremented per accepted word.
- REQ-023 GRANT SHALL exit to IDLE after the cycle that accepts a word with req_last=1, or that accepts word number MAX_BURST; on exit, rr_ptr SHALL be set to grant_id+1 mod 4.
- REQ-024 If req_valid of the granted requester drops mid-burst, SHALL remain in GRANT and wait, without a timeout.
- REQ-025 When the final accept and release occur in the same cycle, the next arbitration SHALL start in the following IDLE cycle, while the output register drains independently.
- REQ-026 data_in bits [3:0] SHALL carry nibble 0 exactly as received; no reordering.

Reset
- REQ-027 Asserting res_n low SHALL asynchronously force state=IDLE, rr_ptr=0, burst counter=0, ovalid=0, odata=0, grant_id=0.
- REQ-028 During reset, outputs SHALL be shift_in=0, data_in=0, req_ready=0, busy=0.
- REQ-029 Reset mid-burst SHALL discard the pending output word and any partial packet; there is no recovery.
- REQ-030 After deassertion, the first grant SHALL be decided in the first IDLE cycle.

Structure
- REQ-031 A shared package gearbox_pkg SHALL hold the state encoding (IDLE=0, GRANT=1), GB_WORD_W=16, and NUM_REQ_MAX=4.
- REQ-032 The round-robin selector SHALL be a sub-module rr_pick4 (inputs: req, ptr; outputs: found, idx), purely combinational.
- REQ-033 The rest of the block SHALL be a single module with no memories.

Verification
- REQ-034 Single requester: req 0 sends 3 words 0x1111, 0x2222, 0x3333 (last on the third), full=0 -> shift_in high 3 consecutive cycles starting 2 cycles after req_valid, data in order, busy drops after the third accept.
- REQ-035 Round-robin: req 0 and req 2 each send 1-word packets continuously -> grant_id alternates 0, 2, 0, 2 and never repeats while the other requester is valid.
- REQ-036 Burst cap: MAX_BURST=8, req 1 sends 12 words with no last, req 3 valid -> after 8 accepts grant moves to 3, then req 1 resumes and receives its remaining 4 words.
- REQ-037 Backpressure: full held high 5 cycles mid-packet -> shift_in stays high with a stable data_in, req_ready=0, and no duplicate or lost word after full falls.
- REQ-038 Reset mid-burst: res_n pulsed low after 2 of 4 words -> shift_in=0 immediately, then rr_ptr=0 and req 0 has priority on restart.

Source files
------------

// File: rtl/gearbox_pkg.sv
// Shared definitions for the gearbox write arbiter: FSM encoding and word geometry.
package gearbox_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int GB_WORD_W   = 16;
  localparam int NUM_REQ_MAX = 4;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/gearbox_wr_arb_rr_pick4.sv
// Combinational round-robin picker: first set bit of req at or above ptr, wrapping modulo 4.
module rr_pick4
  import gearbox_pkg::*;
(
  input  logic [NUM_REQ_MAX-1:0] req,
  input  logic [1:0]             ptr,
  output logic                   found,
  output logic [1:0]             idx
);

  logic [1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = 0; k < NUM_REQ_MAX; k++) begin
      cand = ptr + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/gearbox_wr_arb.sv
// Round-robin write arbiter feeding a gearbox: a grant is held for one packet or MAX_BURST
// words, and accepted words pass through a single-word output register that stalls on full.
module gearbox_wr_arb
  import gearbox_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                         clk_400MHz,
  input  logic                         res_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*GB_WORD_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         full,
  output logic                         shift_in,
  output logic [GB_WORD_W-1:0]         data_in,
  output logic [1:0]                   grant_id,
  output logic                         busy
);

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  state_e               state_q;
  logic [1:0]           rr_ptr_q;
  logic [1:0]           grant_q;
  logic [3:0]           burst_q;
  logic                 ovalid_q, ovalid_d;
  logic [GB_WORD_W-1:0] odata_q, odata_d;

  logic                 pick_found;
  logic [1:0]           pick_idx;
  logic                 consume;
  logic                 out_free;
  logic                 accept;
  logic                 last_accept;
  logic [GB_WORD_W-1:0] gnt_word;

  rr_pick4 u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // The output slot can take a new word when empty or when its current word leaves this cycle.
  assign consume     = ovalid_q & ~full;
  assign out_free    = ~ovalid_q | consume;
  assign gnt_word    = req_data[{grant_q, 4'h0} +: GB_WORD_W];
  assign accept      = (state_q == GRANT) & out_free & req_valid[grant_q];
  assign last_accept = accept & (req_last[grant_q] | (burst_q == BURST_LAST));

  always_comb begin
    req_ready = '0;
    if ((state_q == GRANT) && out_free) begin
      req_ready[grant_q] = 1'b1;
    end
  end

  always_comb begin
    ovalid_d = ovalid_q;
    odata_d  = odata_q;
    if (accept) begin
      ovalid_d = 1'b1;
      odata_d  = gnt_word;
    end else if (consume) begin
      ovalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_400MHz or negedge res_n) begin
    if (!res_n) begin
      ovalid_q <= 1'b0;
      odata_q  <= '0;
    end else begin
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
    end
  end

  // Arbitration takes one IDLE cycle; release happens on the edge after the final accept.
  always_ff @(posedge clk_400MHz or negedge res_n) begin
    if (!res_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= 2'd0;
      grant_q  <= 2'd0;
      burst_q  <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_q <= pick_idx;
            burst_q <= 4'd0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (accept) begin
            burst_q <= burst_q + 4'd1;
          end
          if (last_accept) begin
            state_q  <= IDLE;
            rr_ptr_q <= next_idx(grant_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign shift_in = ovalid_q;
  assign data_in  = odata_q;
  assign grant_id = grant_q;
  assign busy     = (state_q == GRANT);

endmodule
